data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning added access latency in cycles, legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset; synchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ack  input  1  initiator consumes the response.
REQ-014 resp_rdata  output  32  load result; 0 for stores and for errors.
REQ-015 resp_err  output  1  request was misaligned, out of range, or illegal size.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, ACCESS, RESP, with req_ready=1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready; req_we, req_addr, req_size, req_unsigned and req_wdata are captured on that edge.
REQ-018 Error condition: size 3; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:ADDR_W+2]!=0.
REQ-019 On accept with an error, next state SHALL be RESP with resp_err=1 and resp_rdata=0; memory is not modified.
REQ-020 On accept without an error, next state SHALL be WAIT with counter=WAIT_CYCLES-1, or ACCESS when WAIT_CYCLES=0.
REQ-021 WAIT SHALL decrement the counter each cycle and go to ACCESS on the edge where the counter is 0, giving exactly WAIT_CYCLES cycles in WAIT.
REQ-022 ACCESS SHALL last one cycle, then go to RESP.
- Store: write only the byte lanes selected by size and addr[1:0], with wdata shifted to lane position.
- Load: read the word at addr[ADDR_W+1:2].
REQ-023 Load result SHALL select the byte or half at lane addr[1:0] and extend it to 32 bits per req_unsigned; word loads pass through unchanged.
REQ-024 resp_valid SHALL first be 1 exactly WAIT_CYCLES+2 edges after the accepting edge for legal requests, and 1 edge after for errors.
REQ-025 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ack=1; that edge returns to IDLE.
REQ-026 resp_ack while resp_valid=0 SHALL be ignored.
REQ-027 A new request SHALL NOT be accepted on the same edge that consumes a response; req_ready rises the cycle after.
REQ-028 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-029 While reset_n=0 at an edge, the block SHALL go to IDLE, with counter=0, resp_valid=0, resp_err=0, resp_rdata=0 and req_ready=1 after that edge.
REQ-030 Reset mid-operation SHALL abort any pending request; a store that has not reached ACCESS SHALL NOT modify memory.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 State enum, size codes (SIZE_B/H/W) and the WAIT_CYCLES width constant SHALL live in the shared define package.
REQ-033 The word array with byte-enable write and registered read SHALL be one sub-module, mem_bank_be; the FSM, alignment check and lane extraction stay in data_mem_responder.

Verification
REQ-034 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid 4 edges after accept (WAIT_CYCLES=2).
REQ-035 Byte store 0x80 to 0x13, then byte load 0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x10 -> 0x80ADBEEF.
REQ-036 Half load at 0x11 -> err 1, rdata 0, resp_valid 1 edge after accept; word at 0x10 unchanged.
REQ-037 Load at address 1<<(ADDR_W+2) -> err 1; size 3 -> err 1.
REQ-038 Hold resp_ack=0 for 5 cycles -> outputs stable and req_ready=0; ack -> req_ready=1 the next cycle.
REQ-039 Store accepted, reset_n=0 during WAIT -> IDLE, and a later load of that address returns the old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM states, access size codes,
// wait-counter width and the byte-lane enable helper.
`timescale 1ns/1ps
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Wide enough for the largest legal WAIT_CYCLES (15).
  localparam int WAIT_CW = 4;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Word-organised RAM, byte-enable write and registered read-before-write, one access per enable.
// Latency: read data valid the cycle after i_en; no backpressure, contents are never reset.
`timescale 1ns/1ps
module mem_bank_be #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: legal requests answer WAIT_CYCLES+2 edges after accept,
// errors after 1; accepts only in IDLE and holds the response until resp_ack.
`timescale 1ns/1ps
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ack,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [WAIT_CW-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CW'(WAIT_CYCLES - 1);

  state_e               r_state, w_state_nxt;
  logic [WAIT_CW-1:0]   r_cnt, w_cnt_nxt;

  logic                 r_we, r_uns, r_err;
  logic [1:0]           r_size, r_off;
  logic [ADDR_W-1:0]    r_word;
  logic [31:0]          r_wdata;

  logic                 w_accept, w_req_err, w_hi_nz;
  logic                 w_mem_en;
  logic [3:0]           w_mem_be;
  logic [31:0]          w_mem_wdata, w_mem_rdata, w_lane, w_load;

  // Any address bit above the memory's byte span makes the request out of range.
  assign w_hi_nz  = |req_addr[31:ADDR_W+2];
  assign w_accept = req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      SIZE_B:  w_req_err = 1'b0;
      SIZE_H:  w_req_err = req_addr[0];
      SIZE_W:  w_req_err = |req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
    w_req_err = w_req_err | w_hi_nz;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt = ST_RESP;
          end else if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_ACCESS;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_ACCESS: begin
        w_mem_en    = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_accept) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_err   <= w_req_err;
      r_size  <= req_size;
      r_off   <= req_addr[1:0];
      r_word  <= req_addr[ADDR_W+1:2];
      r_wdata <= req_wdata;
    end
  end

  assign w_mem_be    = lane_be(r_size, r_off);
  assign w_mem_wdata = r_wdata << {r_off, 3'b000};

  mem_bank_be #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_be    (w_mem_be),
    .i_addr  (r_word),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Read data stays in the bank's output register through RESP, so extraction can be combinational.
  assign w_lane = w_mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      SIZE_B:  w_load = r_uns ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      SIZE_H:  w_load = r_uns ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_mem_rdata;
    endcase
  end

  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_we) ? w_load : 32'h0;

endmodule
